// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding
// and default bit timing.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int CLKS_PER_BIT_DEFAULT = 868;
   localparam int BYTE_SIZE_DEFAULT    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter: half-period load on a start edge,
// full-period reload on every tick while running.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic load_half,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] bt_cnt;

   // The counter parks at zero while idle so a fresh half load always starts clean.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         bt_cnt <= '0;
      end else if (load_half) begin
         bt_cnt <= HALF_LOAD;
      end else if (!run) begin
         bt_cnt <= '0;
      end else if (bt_cnt == '0) begin
         bt_cnt <= FULL_LOAD;
      end else begin
         bt_cnt <= bt_cnt - 1'b1;
      end
   end

   assign tick = run && (bt_cnt == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchroniser, start-edge detection, mid-bit
// sampling, sequencing of the external byte receiver and the output port.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int BYTE_SIZE    = BYTE_SIZE_DEFAULT,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 rx_line,
   output logic                 br_en,
   output logic                 br_in_bit,
   output logic                 br_init_frame,
   input  logic                 br_out_valid,
   input  logic [BYTE_SIZE-1:0] br_out_data,
   output logic [BYTE_SIZE-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 ovr_clr,
   output logic                 busy
);

   localparam int BC_W = $clog2(BYTE_SIZE) + 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BYTE_SIZE - 1);

   rx_state_t            state;
   logic                 rx_sync1;
   logic                 rx_s;
   logic                 rx_prev;
   logic                 fall_edge;
   logic                 tick;
   logic [BC_W-1:0]      bit_cnt;
   logic [BYTE_SIZE-1:0] hold;
   logic [BYTE_SIZE-1:0] byte_rev;
   logic                 have_byte;
   logic                 stop_tick;
   logic                 deliver;
   logic                 blocked;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rx_sync1 <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
      end else begin
         rx_sync1 <= rx_line;
         rx_s     <= rx_sync1;
         rx_prev  <= rx_s;
      end
   end

   assign fall_edge = rx_prev && !rx_s;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .load_half ((state == ST_IDLE) && fall_edge),
      .run       (state != ST_IDLE),
      .tick      (tick)
   );

   // Every br_* output is a registered single-cycle pulse; the idle value of
   // br_in_bit is 1 so a stray enable never looks like a start bit.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= ST_IDLE;
         bit_cnt       <= '0;
         br_en         <= 1'b0;
         br_in_bit     <= 1'b1;
         br_init_frame <= 1'b0;
         busy          <= 1'b0;
      end else begin
         br_en         <= 1'b0;
         br_in_bit     <= 1'b1;
         br_init_frame <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fall_edge) begin
                  br_en         <= 1'b1;
                  br_init_frame <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  br_en     <= 1'b1;
                  br_in_bit <= rx_s;
                  if (rx_s) begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     bit_cnt <= '0;
                     state   <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  br_en     <= 1'b1;
                  br_in_bit <= rx_s;
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  br_en <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // The byte receiver shifts MSB-first, the wire is LSB-first.
   always_comb begin
      byte_rev = '0;
      for (int i = 0; i < BYTE_SIZE; i++) begin
         byte_rev[i] = br_out_data[BYTE_SIZE-1-i];
      end
   end

   assign stop_tick = (state == ST_STOP) && tick;
   assign deliver   = stop_tick && (have_byte || br_out_valid);
   assign blocked   = rx_valid && !rx_ready;

   // A byte still waiting for the consumer at the stop sample wins; the new
   // one is dropped and flagged, and a set beats a clear in the same cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hold         <= '0;
         have_byte    <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && fall_edge) begin
            have_byte <= 1'b0;
         end else if (br_out_valid) begin
            have_byte <= 1'b1;
            hold      <= byte_rev;
         end

         if (deliver && !blocked) begin
            rx_data      <= br_out_valid ? byte_rev : hold;
            rx_frame_err <= !rx_s;
            rx_valid     <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (deliver && blocked) begin
            rx_overrun <= 1'b1;
         end else if (ovr_clr) begin
            rx_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural byte-receiver neighbour
// and an expected-byte queue drained by an independent monitor.
module tb_uart_rx_ctrl;

   localparam int CPB      = 16;
   localparam int BYTE     = 8;
   localparam int STOP_OFS = CPB * (BYTE + 1);
   localparam int S_OFS    = 2 + CPB/2 + (BYTE + 1) * CPB;
   localparam int PULSES   = BYTE + 3;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      int         rise;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       rx_line = 1'b1;
   logic       br_en;
   logic       br_in_bit;
   logic       br_init_frame;
   logic       br_out_valid = 1'b0;
   logic [7:0] br_out_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       ovr_clr = 1'b0;
   logic       busy;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   en_count = 0;
   logic held = 1'b0;
   logic exp_ovr = 1'b0;
   logic valid_q = 1'b0;
   exp_t sb[$];

   int         br_phase = 0;
   int         br_cnt = 0;
   logic [7:0] br_shift = 8'h00;

   uart_rx_ctrl #(
      .BYTE_SIZE    (BYTE),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .rx_line       (rx_line),
      .br_en         (br_en),
      .br_in_bit     (br_in_bit),
      .br_init_frame (br_init_frame),
      .br_out_valid  (br_out_valid),
      .br_out_data   (br_out_data),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun),
      .ovr_clr       (ovr_clr),
      .busy          (busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Neighbouring byte receiver: 0 = no data, 1 = awaiting start, 2 = shifting.
   always @(posedge CLK) begin
      br_out_valid <= 1'b0;
      if (!RST_N) begin
         br_phase    <= 0;
         br_cnt      <= 0;
         br_shift    <= 8'h00;
         br_out_data <= 8'h00;
      end else if (br_en) begin
         if (br_init_frame) begin
            br_phase <= 1;
         end else if (br_phase == 1) begin
            br_phase <= br_in_bit ? 0 : 2;
            br_cnt   <= 0;
         end else if (br_phase == 2) begin
            br_shift <= {br_shift[6:0], br_in_bit};
            br_cnt   <= br_cnt + 1;
            if (br_cnt == BYTE - 1) begin
               br_out_valid <= 1'b1;
               br_out_data  <= {br_shift[6:0], br_in_bit};
               br_phase     <= 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_br_en", 32'(br_en), 32'd0);
      checkOutput("rst_br_in_bit", 32'(br_in_bit), 32'd1);
      checkOutput("rst_br_init_frame", 32'(br_init_frame), 32'd0);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_rx_frame_err", 32'(rx_frame_err), 32'd0);
      checkOutput("rst_rx_overrun", 32'(rx_overrun), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
   endtask

   task automatic idleCycles(input int n);
      rx_line = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // One full frame on the wire, expectation pushed up front. rst_at >= 0
   // pulses reset at that offset and abandons the frame.
   task automatic applyStimulus(input logic [7:0] data, input logic stop, input int low_hold,
                                input int gap, input logic clr_at_s, input int rst_at);
      int   c0;
      int   stop_len;
      int   total;
      exp_t e;
      c0       = cyc;
      en_count = 0;
      stop_len = stop ? CPB : low_hold;
      total    = STOP_OFS + stop_len + gap;
      if (rst_at < 0) begin
         if (held) begin
            exp_ovr = 1'b1;
         end else begin
            e.data = data;
            e.ferr = !stop;
            e.rise = c0 + S_OFS + 1;
            sb.push_back(e);
            if (!rx_ready) held = 1'b1;
         end
      end
      for (int t = 0; t < total; t++) begin
         if (t < CPB)                        rx_line = 1'b0;
         else if (t < STOP_OFS)              rx_line = data[3'((t - CPB) / CPB)];
         else if (t < STOP_OFS + stop_len)   rx_line = stop;
         else                                rx_line = 1'b1;
         ovr_clr = clr_at_s && (cyc == c0 + S_OFS);
         RST_N   = (t == rst_at) ? 1'b0 : 1'b1;
         if (rst_at >= 0 && t == rst_at + 1) begin
            checkResetValues();
            rx_line = 1'b1;
            sb.delete();
            held    = 1'b0;
            exp_ovr = 1'b0;
            return;
         end
         if (t == CPB + 4) checkOutput("busy_in_frame", 32'(busy), 32'd1);
         if (!stop && t == STOP_OFS + stop_len - 1) begin
            checkOutput("busy_after_bad_stop", 32'(busy), 32'd0);
            checkOutput("pulses_while_low", 32'(en_count), 32'(PULSES));
         end
         @(negedge CLK);
      end
      ovr_clr = 1'b0;
      checkOutput("br_en_pulses", 32'(en_count), 32'(PULSES));
   endtask

   task automatic sendGlitch();
      int c0;
      c0       = cyc;
      en_count = 0;
      for (int t = 0; t < 34; t++) begin
         rx_line = (t < 4) ? 1'b0 : 1'b1;
         if (t == 5)  checkOutput("glitch_busy_start", 32'(busy), 32'd1);
         if (t == 12) checkOutput("glitch_busy_after_tick", 32'(busy), 32'd0);
         @(negedge CLK);
      end
      checkOutput("glitch_pulses", 32'(en_count), 32'd2);
      checkOutput("glitch_no_valid", 32'(rx_valid), 32'd0);
      if (cyc < c0) $display("[TB] cycle counter wrapped");
   endtask

   task automatic pulseOvrClr();
      ovr_clr = 1'b1;
      @(negedge CLK);
      ovr_clr = 1'b0;
      exp_ovr = 1'b0;
      @(negedge CLK);
      checkOutput("overrun_cleared", 32'(rx_overrun), 32'(exp_ovr));
   endtask

   // Monitor: counts br_en pulses, checks rx_valid rise timing, pops on accept.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (br_en === 1'b1) en_count++;
         if (rx_valid === 1'b1 && !valid_q) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_valid", 32'(rx_valid), 32'd0);
            end else begin
               checkOutput("rx_valid_rise_cycle", 32'(cyc), 32'(sb[0].rise));
            end
         end
         valid_q = (rx_valid === 1'b1);
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_accept", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               checkOutput("rx_data", 32'(rx_data), 32'(e.data));
               checkOutput("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] rdata;
      logic       rstop;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      checkResetValues();
      RST_N = 1'b1;
      idleCycles(10);

      applyStimulus(8'h5A, 1'b1, 0, 10, 1'b0, -1);
      sendGlitch();
      applyStimulus(8'h3C, 1'b0, 40, 10, 1'b0, -1);
      applyStimulus(8'h00, 1'b1, 0, 0, 1'b0, -1);
      applyStimulus(8'hFF, 1'b1, 0, 10, 1'b0, -1);

      rx_ready = 1'b0;
      applyStimulus(8'h11, 1'b1, 0, 0, 1'b0, -1);
      applyStimulus(8'h22, 1'b1, 0, 10, 1'b0, -1);
      checkOutput("overrun_set", 32'(rx_overrun), 32'(exp_ovr));
      checkOutput("held_data", 32'(rx_data), 32'h11);
      checkOutput("held_valid", 32'(rx_valid), 32'd1);
      pulseOvrClr();
      applyStimulus(8'h33, 1'b1, 0, 10, 1'b1, -1);
      checkOutput("overrun_set_beats_clear", 32'(rx_overrun), 32'(exp_ovr));
      checkOutput("held_data_after_third", 32'(rx_data), 32'h11);
      rx_ready = 1'b1;
      idleCycles(5);

      applyStimulus(8'h77, 1'b1, 0, 0, 1'b0, 88);
      idleCycles(20);
      applyStimulus(8'hA5, 1'b1, 0, 10, 1'b0, -1);

      for (int i = 0; i < 10; i++) begin
         rdata = 8'($urandom);
         rstop = ($urandom_range(0, 3) != 0);
         if (rstop) applyStimulus(rdata, 1'b1, 0, $urandom_range(0, 12), 1'b0, -1);
         else       applyStimulus(rdata, 1'b0, $urandom_range(16, 40), $urandom_range(3, 12), 1'b0, -1);
      end

      idleCycles(20);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      checkOutput("overrun_final", 32'(rx_overrun), 32'(exp_ovr));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Bit-timing and framing controller for the UART receive path. It synchronises the raw serial line, finds start-bit edges, and times mid-bit samples. It sequences `uart_byte_rx` through its `en` / `init_frame` / `in_bit` inputs, checks the stop bit itself, and presents each received byte on a valid/ready port with framing-error and overrun status. It sits between the pad-side RX pin and the byte consumer (command parser / RX FIFO).

## Interface
- `BYTE_SIZE`, 8: data bits per frame; must match the attached `uart_byte_rx`.
- `CLKS_PER_BIT`, 868: CLK cycles per bit; even, minimum 8.
- `CLK` input 1: clock.
- `RST_N` input 1: synchronous, active-low reset.
- `rx_line` input 1: asynchronous serial input; idle high.
- `br_en` output 1: enable pulse to `uart_byte_rx.en`.
- `br_in_bit` output 1: bit value to `uart_byte_rx.in_bit`.
- `br_init_frame` output 1: to `uart_byte_rx.init_frame`.
- `br_out_valid` input 1: from `uart_byte_rx.out_valid`.
- `br_out_data` input BYTE_SIZE: from `uart_byte_rx.out_data`.
- `rx_data` output BYTE_SIZE: received byte, LSB = first wire bit.
- `rx_valid` output 1: `rx_data`/`rx_frame_err` valid.
- `rx_ready` input 1: consumer accepts when `rx_valid && rx_ready`.
- `rx_frame_err` output 1: stop bit of the presented byte was 0.
- `rx_overrun` output 1: sticky; a byte was dropped.
- `ovr_clr` input 1: one-cycle clear of `rx_overrun`.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchroniser: 2 flops (reset 1) on `rx_line` give `rx_s`; `rx_prev` (reset 1) holds the previous `rx_s`. Falling edge = `rx_prev && !rx_s`.
- Bit timer: down-counter `bt_cnt`, width `$clog2(CLKS_PER_BIT)`. "Tick" means `bt_cnt == 0` in START/DATA/STOP. Each tick reloads `CLKS_PER_BIT-1`.
- **IDLE**
  - On a falling edge: load `bt_cnt = CLKS_PER_BIT/2 - 1`, issue init pulse (`br_en=1`, `br_init_frame=1`, `br_in_bit=1`), go to START.
  - A low line without a preceding high (break, or a bad stop) never starts a frame.
- **START**, on tick, issue `br_en=1`, `br_in_bit=rx_s`:
  - `rx_s=1`: glitch. Byte receiver falls back to NO_DATA by itself; go to IDLE, no output.
  - `rx_s=0`: clear `bit_cnt`, go to DATA.
- **DATA**, on tick: `br_en=1`, `br_in_bit=rx_s`, `bit_cnt++`. After the BYTE_SIZE-th bit go to STOP.
- **Byte capture**: on `br_out_valid`, latch `hold = bit-reverse(br_out_data)`, i.e. `hold[i] = br_out_data[BYTE_SIZE-1-i]`.
- **STOP**, on tick (sample point S):
  - `stop_ok = rx_s`.
  - Issue flush pulse (`br_en=1`, `br_in_bit=1`, `br_init_frame=0`). This forces the byte receiver from its START state back to NO_DATA.
  - Go to IDLE.
- **Output register**, at S:
  - If `rx_valid && !rx_ready`: drop the new byte and set `rx_overrun`.
  - Otherwise load `rx_data = hold`, `rx_frame_err = !stop_ok`, `rx_valid = 1`.
- A frame-errored byte is still delivered, with `rx_frame_err=1`.
- `rx_valid` clears on accept unless it is reloaded in the same cycle.
- `rx_overrun`: set wins over `ovr_clr` in the same cycle.
- Reset, including mid-frame: state = IDLE, counters 0, all outputs at reset values. The integrator drives the byte receiver's `RST` from `!RST_N` so both blocks restart together.

## Timing
- Reset values: `br_en=0`, `br_in_bit=1`, `br_init_frame=0`, `rx_data=0`, `rx_valid=0`, `rx_frame_err=0`, `rx_overrun=0`, `busy=0`.
- All `br_*` outputs are registered, one-cycle pulses that appear the cycle after their decision point.
- Reference cycle F = first cycle with `rx_s=0` after the edge. Sample points:
  - start bit at F + CLKS_PER_BIT/2;
  - data bit k (0-based) at F + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit S at F + CLKS_PER_BIT/2 + (BYTE_SIZE+1)·CLKS_PER_BIT.
- Pulse count:
  - good frame: exactly BYTE_SIZE + 3 `br_en` pulses;
  - glitch: exactly 2.
- `rx_valid` rises at S+1. `br_out_valid` always arrives by S; if it has not, no byte is presented.
- Back-to-back frames are supported: IDLE is re-entered at S+1, and a new edge may arrive at S + CLKS_PER_BIT/2.

## Structure
- Package `uart_pkg`:
  - state encoding `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_STOP`;
  - default `CLKS_PER_BIT`.
- Sub-module `uart_bit_timer`: reloadable down-counter with half/full load and tick output.
- `uart_byte_rx` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use `CLKS_PER_BIT=16`, `BYTE_SIZE=8`.
- 0x5A frame, stop=1, `rx_ready=1` -> `rx_data=0x5A`, `rx_frame_err=0`, 11 `br_en` pulses, `rx_valid` at S+1.
- Line low for 4 clocks then high -> 2 `br_en` pulses, no `rx_valid`, `busy` low after the start tick.
- 0x3C frame with stop=0, line held low 40 cycles, then high -> `rx_data=0x3C` with `rx_frame_err=1`; no new frame until the line returns high and falls again.
- Back-to-back 0x00 then 0xFF, minimum gap -> two accepted bytes, both `rx_frame_err=0`.
- `rx_ready=0`, frames 0x11 then 0x22 -> `rx_data` stays 0x11, `rx_overrun=1`; `ovr_clr` clears it; the simultaneous set+clear case leaves it set.
- `RST_N=0` during DATA bit 4 -> all outputs at reset values next cycle; a following 0xA5 frame is received correctly.
